// File: rtl/uart_rx_data_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_data_sampler
//
// UART receive front-end. While enabled by the Rx FSM it walks an edge counter
// through each bit period (P clocks), counts completed bit periods, captures
// RX_IN three times around mid-bit and majority-votes those captures into
// sampled_bit, qualified by a single-cycle sample_valid strobe.
//
// Ports
//   CLK          system clock, rising edge
//   RST          synchronous, active-high reset
//   dat_samp_en  enable from the Rx FSM; low clears the counters
//   RX_IN        serial line, already synchronised to CLK
//   Prescale     oversampling ratio (8, 16 or 32; anything else acts as 8)
//   edge_cnt     position inside the current bit period, 0..P-1
//   bit_cnt      completed bit periods since enable, saturating at all-ones
//   sampled_bit  majority-voted value of the most recent bit
//   sample_valid one-cycle strobe, sampled_bit updated this cycle
// -----------------------------------------------------------------------------
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  dat_samp_en,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  // Only 8, 16 and 32 are supported ratios; anything else falls back to 8 so
  // the sample positions always stay inside the bit period.
  function automatic logic [PRESCALE_W-1:0] eff_prescale(
    input logic [PRESCALE_W-1:0] p
  );
    logic [PRESCALE_W-1:0] r;
    case (p)
      PRESCALE_W'(8), PRESCALE_W'(16), PRESCALE_W'(32): r = p;
      default:                                          r = PRESCALE_W'(8);
    endcase
    return r;
  endfunction

  // 2-of-3 vote: a single glitched sample cannot flip the bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_pos;
  logic [PRESCALE_W-1:0] pos_s0;
  logic [PRESCALE_W-1:0] pos_s1;
  logic [PRESCALE_W-1:0] pos_s2;
  logic [PRESCALE_W-1:0] pos_vote;
  logic                  at_wrap;
  logic                  at_vote;
  logic                  bit_cnt_full;

  logic s0;
  logic s1;
  logic s2;

  // Sample positions are H-2, H-1, H and the vote lands at H+1, where H=P/2.
  // For every legal P the vote position is strictly below P-1, so a strobe and
  // a wrap never coincide.
  always_comb begin
    p_eff        = eff_prescale(Prescale);
    half         = p_eff >> 1;
    last_pos     = p_eff - PRESCALE_W'(1);
    pos_s0       = half - PRESCALE_W'(2);
    pos_s1       = half - PRESCALE_W'(1);
    pos_s2       = half;
    pos_vote     = half + PRESCALE_W'(1);
    at_wrap      = (edge_cnt == last_pos);
    at_vote      = (edge_cnt == pos_vote);
    bit_cnt_full = (bit_cnt == {BIT_CNT_W{1'b1}});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      s2           <= 1'b0;
    end else if (!dat_samp_en) begin
      // Idle: counters restart so the next enable begins a fresh bit period.
      // The last voted bit and the raw samples are left untouched.
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      sample_valid <= 1'b0;
    end else begin
      edge_cnt <= at_wrap ? '0 : edge_cnt + PRESCALE_W'(1);

      // Saturate rather than wrap so a runaway frame never looks like a
      // freshly started one.
      if (at_wrap && !bit_cnt_full) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end

      if (edge_cnt == pos_s0) s0 <= RX_IN;
      if (edge_cnt == pos_s1) s1 <= RX_IN;
      if (edge_cnt == pos_s2) s2 <= RX_IN;

      sample_valid <= at_vote;
      if (at_vote) begin
        sampled_bit <= majority3(s0, s1, s2);
      end
    end
  end

endmodule
